// File: rtl/crossbar_pkg.sv
// Shared types and widths for the crossbar slave responder.
package crossbar_pkg;

    localparam int ADDR_W = 31;
    localparam int DATA_W = 32;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_e;

endpackage

// File: rtl/crossbar_slave_responder_if.sv
// Slave-side bus of one crossbar port: request toward the responder, ack/rdata back.
interface crossbar_slave_responder_if;
    import crossbar_pkg::*;

    logic              slave_req;
    cmd_e              slave_cmd;
    logic [ADDR_W-1:0] slave_addr;
    logic [DATA_W-1:0] slave_wdata;
    logic              slave_ack;
    logic [DATA_W-1:0] slave_rdata;

    // Crossbar side
    modport master (
        output slave_req, slave_cmd, slave_addr, slave_wdata,
        input  slave_ack, slave_rdata
    );

    // Responder side
    modport slave (
        input  slave_req, slave_cmd, slave_addr, slave_wdata,
        output slave_ack, slave_rdata
    );

endinterface

// File: rtl/crossbar_slave_mem.sv
// DEPTH x DATA_W register file: one write port, one registered read port.
// The read port returns 0 whenever no read is requested, so rdata is a
// single-cycle pulse carrying the read value.
module crossbar_slave_mem
    import crossbar_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    // Storage update, registered read; reset clears every word.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem   <= '0;
            rdata <= '0;
        end else begin
            if (we) mem[idx] <= wdata;
            rdata <= re ? mem[idx] : '0;
        end
    end

endmodule

// File: rtl/crossbar_slave_responder.sv
// Responder for one crossbar slave port: latches a request, inserts
// WAIT_CYCLES wait states, acks for one cycle, and serves reads/writes
// from a small register file. Counts completed reads/writes (saturating)
// and flags requests withdrawn during the wait phase.
module crossbar_slave_responder
    import crossbar_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    crossbar_slave_responder_if.slave   bus,
    output logic [CNT_W-1:0]            rd_count,
    output logic [CNT_W-1:0]            wr_count,
    output logic                        proto_err
);

    localparam int IDX_W = $clog2(DEPTH);
    // WAIT is skipped entirely when WAIT_CYCLES = 0, so the load value is
    // only meaningful for non-zero settings.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e            state, state_d;
    logic [3:0]        wait_cnt, wait_cnt_d;
    logic              latch;
    logic              err_set;
    logic              mem_we, mem_re;
    cmd_e              cmd_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;

    // Upper address bits alias onto the same words.
    logic unused_addr;
    assign unused_addr = ^bus.slave_addr[ADDR_W-1:IDX_W];

    // Ack is decoded straight from the state register, so it is glitch-free.
    assign bus.slave_ack = (state == ST_ACK);

    // Next-state, wait countdown and per-state strobes.
    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        latch      = 1'b0;
        err_set    = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.slave_req) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.slave_req) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else if (wait_cnt == 4'd0) begin
                    state_d = ST_ACK;
                end else begin
                    wait_cnt_d = wait_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                mem_we  = (cmd_q == CMD_WRITE);
                mem_re  = (cmd_q == CMD_READ);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, request capture, sticky error and saturating counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            cmd_q     <= CMD_READ;
            idx_q     <= '0;
            wdata_q   <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            proto_err <= 1'b0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            if (latch) begin
                cmd_q   <= bus.slave_cmd;
                idx_q   <= bus.slave_addr[IDX_W-1:0];
                wdata_q <= bus.slave_wdata;
            end
            if (err_set) proto_err <= 1'b1;
            if (mem_we && (wr_count != '1)) wr_count <= wr_count + 1'b1;
            if (mem_re && (rd_count != '1)) rd_count <= rd_count + 1'b1;
        end
    end

    crossbar_slave_mem #(.DEPTH(DEPTH)) u_mem (
        .clock (clock),
        .reset (reset),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (bus.slave_rdata)
    );

endmodule

// File: tb/tb_crossbar_slave_responder.sv
// Scoreboard bench: three responders (2 wait states; 0 wait states;
// 1 wait state with 2-bit counters). Stimulus pushes expected acks and
// status snapshots; a negedge monitor pops and compares.
module tb_crossbar_slave_responder;
    import crossbar_pkg::*;

    typedef struct {
        int          k;
        bit          is_read;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        int k;
        int rd;
        int wr;
        bit err;
    } st_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    logic        drv_req[3];
    logic        drv_cmd[3];
    logic [30:0] drv_addr[3];
    logic [31:0] drv_wdata[3];
    logic        mon_ack[3];
    logic [31:0] mon_rdata[3];
    logic [15:0] mon_rd[3];
    logic [15:0] mon_wr[3];
    logic        mon_err[3];

    logic [15:0] rdc0, wrc0, rdc1, wrc1;
    logic [1:0]  rdc2, wrc2;
    logic        err0, err1, err2;

    exp_t exp_q[$];
    st_t  st_q[$];
    bit          rd_pending[3];
    logic [31:0] rd_exp[3];

    crossbar_slave_responder_if bus[3] ();

    for (genvar g = 0; g < 3; g++) begin : g_wire
        assign bus[g].slave_req   = drv_req[g];
        assign bus[g].slave_cmd   = cmd_e'(drv_cmd[g]);
        assign bus[g].slave_addr  = drv_addr[g];
        assign bus[g].slave_wdata = drv_wdata[g];
        assign mon_ack[g]         = bus[g].slave_ack;
        assign mon_rdata[g]       = bus[g].slave_rdata;
    end

    assign mon_rd[0] = rdc0;          assign mon_wr[0] = wrc0;          assign mon_err[0] = err0;
    assign mon_rd[1] = rdc1;          assign mon_wr[1] = wrc1;          assign mon_err[1] = err1;
    assign mon_rd[2] = {14'b0, rdc2}; assign mon_wr[2] = {14'b0, wrc2}; assign mon_err[2] = err2;

    crossbar_slave_responder #(.DEPTH(16), .WAIT_CYCLES(2), .CNT_W(16)) dut0 (
        .clock(clock), .reset(reset), .bus(bus[0]),
        .rd_count(rdc0), .wr_count(wrc0), .proto_err(err0));
    crossbar_slave_responder #(.DEPTH(16), .WAIT_CYCLES(0), .CNT_W(16)) dut1 (
        .clock(clock), .reset(reset), .bus(bus[1]),
        .rd_count(rdc1), .wr_count(wrc1), .proto_err(err1));
    crossbar_slave_responder #(.DEPTH(4), .WAIT_CYCLES(1), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .bus(bus[2]),
        .rd_count(rdc2), .wr_count(wrc2), .proto_err(err2));

    always #5 clock = ~clock;

    // Cycle index; a request set just after edge N is first sampled in cycle N.
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: rdata every cycle, ack timing/ordering, queued status snapshots.
    always @(negedge clock) begin
        exp_t it;
        st_t  s;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mon_rdata[k] !== (rd_pending[k] ? rd_exp[k] : 32'h0)) begin
                errors++;
                $display("FAIL rdata dut%0d cyc %0d: got %h expected %h", k, cyc, mon_rdata[k],
                         rd_pending[k] ? rd_exp[k] : 32'h0);
            end
            rd_pending[k] = 1'b0;
            if (mon_ack[k] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].k != k) begin
                    errors++;
                    $display("FAIL unexpected_ack dut%0d cyc %0d: got ack, expected none", k, cyc);
                end else begin
                    it = exp_q.pop_front();
                    if (cyc != it.cyc) begin
                        errors++;
                        $display("FAIL ack_cycle dut%0d: got %0d expected %0d", k, cyc, it.cyc);
                    end
                    if (it.is_read) begin
                        rd_pending[k] = 1'b1;
                        rd_exp[k]     = it.data;
                    end
                end
            end
        end
        while (st_q.size() > 0) begin
            s = st_q.pop_front();
            checks += 3;
            if (int'(mon_rd[s.k]) != s.rd) begin
                errors++;
                $display("FAIL rd_count dut%0d cyc %0d: got %0d expected %0d", s.k, cyc, mon_rd[s.k], s.rd);
            end
            if (int'(mon_wr[s.k]) != s.wr) begin
                errors++;
                $display("FAIL wr_count dut%0d cyc %0d: got %0d expected %0d", s.k, cyc, mon_wr[s.k], s.wr);
            end
            if (mon_err[s.k] !== s.err) begin
                errors++;
                $display("FAIL proto_err dut%0d cyc %0d: got %b expected %b", s.k, cyc, mon_err[s.k], s.err);
            end
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_ack: %0d acks outstanding, expected 0", exp_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic status(input int k, input int rd, input int wr, input bit err);
        st_t s;
        s.k = k; s.rd = rd; s.wr = wr; s.err = err;
        st_q.push_back(s);
    endtask

    // Issue one transaction; hold keeps req high into the following IDLE cycle.
    task automatic txn(input int k, input bit wr, input logic [30:0] a,
                       input logic [31:0] d, input logic [31:0] rexp, input bit hold);
        int   w;
        exp_t it;
        w = (k == 0) ? 2 : (k == 1) ? 0 : 1;
        it.k       = k;
        it.is_read = !wr;
        it.data    = rexp;
        it.cyc     = drv_req[k] ? cyc + w + 2 : cyc + w + 1;
        exp_q.push_back(it);
        drv_cmd[k]   = wr;
        drv_addr[k]  = a;
        drv_wdata[k] = d;
        drv_req[k]   = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock); #1;
            if (mon_ack[k] === 1'b1) break;
        end
        if (!hold) begin
            drv_req[k] = 1'b0;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            drv_req[k] = 1'b0; drv_cmd[k] = 1'b0; drv_addr[k] = '0; drv_wdata[k] = '0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) begin
            for (int k = 0; k < 3; k++) status(k, 0, 0, 0);
            @(posedge clock); #1;
        end

        // Two wait states: write/read, aliasing, withdrawn request
        txn(0, 1'b1, 31'h5, 32'hDEADBEEF, 32'h0, 1'b0);
        status(0, 0, 1, 0);
        txn(0, 1'b0, 31'h5, 32'h0, 32'hDEADBEEF, 1'b0);
        status(0, 1, 1, 0);
        txn(0, 1'b1, 31'h15, 32'h12345678, 32'h0, 1'b0);
        txn(0, 1'b0, 31'h5, 32'h0, 32'h12345678, 1'b0);
        status(0, 2, 2, 0);
        drv_cmd[0] = 1'b1; drv_addr[0] = 31'h5; drv_wdata[0] = 32'hBADBAD00; drv_req[0] = 1'b1;
        @(posedge clock); #1;
        drv_req[0] = 1'b0;
        repeat (4) @(posedge clock); #1;
        status(0, 2, 2, 1);
        txn(0, 1'b0, 31'h5, 32'h0, 32'h12345678, 1'b0);
        status(0, 3, 2, 1);

        // Zero wait states: back-to-back writes with req held, then readback
        for (int i = 0; i < 4; i++)
            txn(1, 1'b1, 31'(i), 32'hA0A0_0000 + 32'(i), 32'h0, i != 3);
        status(1, 0, 4, 0);
        for (int i = 0; i < 4; i++)
            txn(1, 1'b0, 31'(i), 32'h0, 32'hA0A0_0000 + 32'(i), 1'b0);
        status(1, 4, 4, 0);

        // Two-bit counters saturate at 3
        for (int i = 0; i < 5; i++) begin
            txn(2, 1'b0, 31'(i), 32'h0, 32'h0, 1'b0);
            status(2, (i < 3) ? i + 1 : 3, 0, 0);
        end

        // Reset in the middle of a write's wait phase
        drv_cmd[0] = 1'b1; drv_addr[0] = 31'h7; drv_wdata[0] = 32'h7777_7777; drv_req[0] = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1; drv_req[0] = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        status(0, 0, 0, 0);
        status(2, 0, 0, 0);
        repeat (3) @(posedge clock); #1;
        txn(0, 1'b0, 31'h7, 32'h0, 32'h0, 1'b0);
        status(0, 1, 0, 0);

        repeat (3) @(posedge clock); #1;
        done = 1'b1;
    end

endmodule

// File: doc/crossbar_slave_responder.md
Name: crossbar_slave_responder

Overview:
- Synthesizable responder for one slave port of the 2x2 crossbar.
- Drives slave_N_ack/slave_N_rdata back toward the crossbar and consumes slave_N_req/cmd/addr/wdata.
- Holds a small register-file memory, inserts a configurable number of wait states, and counts transactions.
- Two instances, one per slave port, form the far end of the fabric in system benches and FPGA bring-up.

Parameters:
- DEPTH, 16: number of 32-bit words; power of two, minimum 2.
- WAIT_CYCLES, 2: wait states between request sampling and ack; range 0..15.
- CNT_W, 16: width of the read and write transaction counters.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- slave_req  input  1  request from the crossbar.
- slave_cmd  input  1  0 = read, 1 = write.
- slave_addr  input  31  word address; the crossbar has already stripped the slave-select bit 31.
- slave_wdata  input  32  write data, valid with req while cmd = 1.
- slave_ack  output  1  one-cycle acceptance pulse.
- slave_rdata  output  32  read data, valid exactly one cycle after the ack of a read.
- rd_count  output  CNT_W  completed reads; saturating.
- wr_count  output  CNT_W  completed writes; saturating.
- proto_err  output  1  sticky flag: request withdrawn before ack.

Behaviour:
- Reset: checked before every other condition in the clocked process.
  - Clears ack, rdata, rd_count, wr_count, proto_err and every memory word to 0.
  - Forces the state to IDLE.
  - Takes effect on the first rising edge where reset = 1, including mid-transaction.
  - An aborted transaction is neither acked nor counted.
- Index: idx = slave_addr[$clog2(DEPTH)-1:0]; upper address bits are ignored, so addresses alias.
- Protocol: the crossbar holds req, cmd, addr and wdata stable from req rise until the cycle ack = 1 is seen.
- IDLE: if req = 1, latch cmd, idx and wdata.
  - If WAIT_CYCLES = 0, go to ACK; otherwise load wait_cnt = WAIT_CYCLES-1 and go to WAIT.
- WAIT: if req = 0, set proto_err = 1 and go to IDLE; no ack, no memory update.
  - Else if wait_cnt = 0, go to ACK; else decrement wait_cnt.
- ACK:
  - slave_ack = 1 for this single cycle; ack is a registered output of the state.
  - A write commits mem[idx] <= wdata at the end of this cycle and increments wr_count.
  - A read registers mem[idx] into slave_rdata for the next cycle and increments rd_count.
  - Always go to IDLE next.
  - A req still high in the following IDLE cycle is treated as a new transaction. Minimum spacing is therefore WAIT_CYCLES+2 cycles per transaction.
- Latency: ack appears WAIT_CYCLES+1 cycles after the first cycle req = 1 is sampled.
- slave_rdata:
  - Holds the read value for exactly one cycle, then returns to 0.
  - Stays 0 after writes.
  - Read-after-write to the same idx returns the new data, because the write committed in an earlier ACK cycle.
- Counters: saturate at all-ones and never wrap.
- proto_err: cleared only by reset. A req drop in IDLE or ACK is legal and not an error.
- The block makes no assumption about cmd values outside the latched cycle.

Decomposition:
- Package crossbar_pkg holds:
  - typedef cmd_e {CMD_READ = 1'b0, CMD_WRITE = 1'b1};
  - typedef state_e {ST_IDLE, ST_WAIT, ST_ACK};
  - constants ADDR_W = 31, DATA_W = 32.
- One sub-module is natural: crossbar_slave_mem, a DEPTH x 32 register file with synchronous reset-clear, one write port and one registered read port.
- The FSM, wait counter and statistics stay in the top module.

Test Plan:
- Reset and idle: hold reset 3 cycles, then idle 5 cycles -> ack = 0, rdata = 0, both counters 0, proto_err = 0 throughout.
- Write then read, WAIT_CYCLES = 2:
  - write addr 0x5, wdata 0xDEADBEEF -> ack exactly 3 cycles after req, wr_count = 1.
  - read addr 0x5 -> ack after 3 cycles, rdata = 0xDEADBEEF in the next cycle only, rd_count = 1.
- Aliasing, DEPTH = 16: write 0x12345678 to addr 0x15, read addr 0x5 -> rdata = 0x12345678.
- Zero wait, WAIT_CYCLES = 0: four back-to-back writes to addrs 0..3 with req held high -> ack every 2nd cycle, wr_count = 4, readback matches.
- Withdrawn request: req dropped during WAIT -> no ack, proto_err = 1 and stays set, memory and counters unchanged.
- Reset mid-operation: assert reset in WAIT of a write to addr 0x7 -> no ack, mem[7] reads back 0 afterwards, wr_count = 0.
- Saturation, CNT_W = 2: 5 reads -> rd_count stays 3.
